delay_ctrl: RTL and testbench
=============================

// Module: delay_ctrl
// PURPOSE
//  Sequencer for the audio delay line (address counter + dual-port RAM). Divides clk
//  into a sample tick, drives the datapath wr/rd strobes and owns the offset register.
//  Holds rd low until the RAM holds at least 'offset' samples (FILL), then streams (RUN).
//  Accepts offset changes through a req/ack handshake, applied only on sample boundaries.
// PARAMETERS
//  A_WIDTH    9   RAM address width; delay range 0 .. 2^A_WIDTH-1 samples
//  DIV_WIDTH  16  width of the sample-period divider
// PORTS
//  clk        in   1          system clock
//  rst        in   1          asynchronous, active-low reset
//  en         in   1          run enable; low forces IDLE
//  div        in   DIV_WIDTH  sample period minus 1 (tick every div+1 clk cycles)
//  off_req    in   1          offset change request (level, held until off_ack)
//  off_val    in   A_WIDTH    requested delay in samples
//  off_ack    out  1          1-cycle pulse: off_val accepted
//  wr         out  1          datapath write strobe (also advances the address counter)
//  rd         out  1          datapath read strobe
//  offset     out  A_WIDTH    delay in effect, wired to the datapath offset input
//  out_valid  out  1          1-cycle pulse: delayed_signal valid (1 cycle after rd)
//  state      out  2          0=IDLE 1=FILL 2=RUN
// BEHAVIOUR
//  Reset: state=IDLE; wr, rd, out_valid, off_ack=0; offset=0; divider and fill_cnt=0.
//   Asserting rst mid-operation clears all of the above immediately (asynchronous).
//  All outputs are registered.
//  Divider: counts 0..div while en=1; tick when count==div, then count returns to 0.
//   en=0 holds count at 0. div=0 -> tick every cycle.
//  wr/rd: pulse high for exactly the one cycle after a tick (never without a tick).
//  fill_cnt (A_WIDTH bits): samples written since the last IDLE->FILL transition;
//   +1 on each wr; saturates at 2^A_WIDTH-1.
//  FSM:
//   IDLE: wr=rd=0. en=1 -> FILL, fill_cnt<=0.
//   FILL: on tick, wr=1, rd=0. If the updated fill_cnt >= offset -> RUN
//    (offset=0 -> RUN after the first write).
//   RUN: on tick, wr=1 and rd=1 in the same cycle; out_valid=1 on the following cycle.
//   Any state with en=0 -> IDLE on the next edge; a tick in that cycle is ignored.
//    fill_cnt is kept until the next IDLE->FILL transition.
//  Offset handshake:
//   - Accepted on any cycle in IDLE, or on a tick cycle in FILL/RUN.
//   - On acceptance: offset<=off_val and off_ack=1 for the following cycle.
//     The wr/rd pulse for that tick uses the new offset.
//   - RUN with new offset > fill_cnt -> FILL (fill_cnt kept); rd stays low until
//     the RAM has caught up. Otherwise remain in RUN.
//   - FILL uses the new offset in its exit check on the same tick.
//   - A new request is not accepted while off_ack is high.
//   - off_req dropped before acceptance -> nothing happens; no ack.
// TESTING
//  1 div=3, IDLE, off_req/off_val=4 -> off_ack next cycle, offset=4; en=1 ->
//    wr every 4 cycles; ticks 1-4 rd=0; tick 5 wr=rd=1, out_valid 1 cycle later.
//  2 div=0, offset=0, en=1 -> FILL for one write, then RUN with wr=rd=1 every cycle
//    and out_valid every cycle after the first read.
//  3 RUN, fill_cnt=10, request offset=20 -> state FILL, 10 ticks with rd=0 and
//    wr=1, then RUN resumes.
//  4 RUN, request offset=5 (< fill_cnt) -> stays RUN; no gap in rd;
//    offset changes exactly at the tick.
//  5 A_WIDTH=9, offset=511 -> 511 writes before the first rd; fill_cnt saturates at 511.
//  6 en=0 mid-FILL -> IDLE next cycle, no wr; rst=0 mid-RUN -> all outputs 0
//    immediately; re-enable restarts with fill_cnt=0.

Source files
------------

// File: rtl/delay_ctrl.sv
// Sequencer for the audio delay line: sample-tick divider, wr/rd strobes, offset register
// and a FILL/RUN state machine that keeps rd low until the RAM holds 'offset' samples.
module delay_ctrl #(
  parameter int A_WIDTH   = 9,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 off_req,
  input  logic [A_WIDTH-1:0]   off_val,
  output logic                 off_ack,
  output logic                 wr,
  output logic                 rd,
  output logic [A_WIDTH-1:0]   offset,
  output logic                 out_valid,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [A_WIDTH-1:0]   fill_q, fill_d;
  logic [A_WIDTH-1:0]   offset_q, offset_d;
  logic                 wr_q, wr_d;
  logic                 rd_q, rd_d;
  logic                 out_valid_q, out_valid_d;
  logic                 off_ack_q, off_ack_d;

  logic                 tick;
  logic                 accept;
  logic [A_WIDTH-1:0]   fill_inc;

  // Offset handshake: off_req is a level held by the requester until it sees the
  // one-cycle off_ack pulse; the transfer happens on the cycle accept is high, and
  // a request seen while off_ack is still high is not taken again.
  always_comb begin
    tick     = en && (cnt_q == div);
    accept   = off_req && !off_ack_q && ((state_q == S_IDLE) || tick);
    fill_inc = (fill_q == {A_WIDTH{1'b1}}) ? fill_q : fill_q + 1'b1;

    cnt_d = '0;
    if (en) begin
      cnt_d = (cnt_q == div) ? '0 : cnt_q + 1'b1;
    end

    offset_d    = accept ? off_val : offset_q;
    off_ack_d   = accept;
    out_valid_d = rd_q;
    state_d     = state_q;
    fill_d      = fill_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FILL;
          fill_d  = '0;
        end
        S_FILL: begin
          if (tick) begin
            wr_d   = 1'b1;
            fill_d = fill_inc;
            if (fill_inc >= offset_d) state_d = S_RUN;
          end
        end
        S_RUN: begin
          // A larger offset than the RAM currently holds drops back to FILL.
          if (tick) begin
            wr_d   = 1'b1;
            fill_d = fill_inc;
            if (offset_d > fill_inc) begin
              state_d = S_FILL;
            end else begin
              rd_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fill_q      <= '0;
      offset_q    <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      out_valid_q <= 1'b0;
      off_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      offset_q    <= offset_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      off_ack_q   <= off_ack_d;
    end
  end

  assign off_ack   = off_ack_q;
  assign wr        = wr_q;
  assign rd        = rd_q;
  assign offset    = offset_q;
  assign out_valid = out_valid_q;
  assign state     = state_q;

endmodule

// File: tb/tb_delay_ctrl.sv
// Directed bench for delay_ctrl: expected rd value of every wr pulse is queued when the
// stimulus is set up and checked as the pulses appear; out_valid follows the expected rd.
module tb_delay_ctrl;

  localparam int A_WIDTH   = 9;
  localparam int DIV_WIDTH = 16;
  localparam int W         = 1;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [DIV_WIDTH-1:0] div;
  logic                 off_req;
  logic [A_WIDTH-1:0]   off_val;
  logic                 off_ack;
  logic                 wr;
  logic                 rd;
  logic [A_WIDTH-1:0]   offset;
  logic                 out_valid;
  logic [1:0]           state;

  logic [W-1:0] exp_q[$];
  logic         exp_ov;
  int           checks;
  int           errors;
  int           ncyc;
  int           last_wr_cyc;
  logic         have_prev;
  int           gap_exp;

  delay_ctrl #(.A_WIDTH(A_WIDTH), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div       (div),
    .off_req   (off_req),
    .off_val   (off_val),
    .off_ack   (off_ack),
    .wr        (wr),
    .rd        (rd),
    .offset    (offset),
    .out_valid (out_valid),
    .state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample on the falling edge and score any wr pulse against the queue.
  task automatic cyc();
    logic [W-1:0] e;
    logic         nxt_ov;
    @(negedge clk);
    ncyc++;
    chk("out_valid", out_valid, exp_ov);
    nxt_ov = 1'b0;
    if (wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", wr, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rd", rd, e);
        nxt_ov = e;
      end
      if (have_prev) chk("wr_period", ncyc - last_wr_cyc, gap_exp);
      last_wr_cyc = ncyc;
      have_prev   = 1'b1;
    end else begin
      chk("rd_without_wr", rd, 0);
    end
    exp_ov = nxt_ov;
  endtask

  task automatic push_n(input int n, input logic rdv);
    for (int i = 0; i < n; i++) exp_q.push_back(rdv);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // From IDLE (en already low): set divider and load an offset through the handshake.
  task automatic idle_cfg(input int d, input int o);
    have_prev = 1'b0;
    cyc();
    chk("idle_state", state, 0);
    div     = DIV_WIDTH'(d);
    off_val = A_WIDTH'(o);
    off_req = 1'b1;
    cyc();
    chk("idle_ack", off_ack, 1);
    chk("idle_offset", offset, o);
    off_req = 1'b0;
    cyc();
    chk("idle_ack_drop", off_ack, 0);
  endtask

  // driver sequence
  initial begin
    int w;
    checks = 0; errors = 0; ncyc = 0; last_wr_cyc = 0;
    have_prev = 1'b0; gap_exp = 1; exp_ov = 1'b0;
    rst = 1'b0; en = 1'b0; div = 16'd3; off_req = 1'b0; off_val = '0;

    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_wr", wr, 0);
    chk("rst_rd", rd, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_off_ack", off_ack, 0);
    chk("rst_offset", offset, 0);
    rst = 1'b1;

    // 1: div=3, offset 4 loaded in IDLE; a held request is not re-taken while ack is high
    off_val = 9'd4;
    off_req = 1'b1;
    cyc();
    chk("t1_ack", off_ack, 1);
    chk("t1_offset", offset, 4);
    off_val = 9'd7;
    cyc();
    chk("t1_ack_block", off_ack, 0);
    chk("t1_offset_hold", offset, 4);
    off_req = 1'b0;
    en = 1'b1;
    gap_exp = 4;
    last_wr_cyc = ncyc;
    have_prev = 1'b1;
    push_n(4, 1'b0);
    push_n(2, 1'b1);
    drain(40);
    chk("t1_run", state, 2);

    // 4: smaller offset in RUN takes effect exactly at the tick, rd keeps going
    off_val = 9'd5;
    off_req = 1'b1;
    push_n(1, 1'b1);
    cyc(); cyc(); cyc();
    chk("t4_offset_before_tick", offset, 4);
    chk("t4_ack_before_tick", off_ack, 0);
    cyc();
    chk("t4_offset_at_tick", offset, 5);
    chk("t4_ack", off_ack, 1);
    chk("t4_state", state, 2);
    off_req = 1'b0;

    // request withdrawn before a tick is ignored
    cyc();
    off_val = 9'd9;
    off_req = 1'b1;
    cyc();
    off_req = 1'b0;
    push_n(1, 1'b1);
    drain(8);
    chk("drop_ack", off_ack, 0);
    chk("drop_offset", offset, 5);

    // 3: fill_cnt=10, offset 20 -> FILL for 10 rd-less ticks, then RUN
    push_n(2, 1'b1);
    drain(10);
    off_val = 9'd20;
    off_req = 1'b1;
    push_n(10, 1'b0);
    push_n(2, 1'b1);
    w = 0;
    do begin
      cyc();
      w++;
    end while (wr !== 1'b1 && w < 8);
    chk("t3_ack", off_ack, 1);
    chk("t3_state_fill", state, 1);
    chk("t3_offset", offset, 20);
    off_req = 1'b0;
    drain(100);
    chk("t3_state_run", state, 2);
    en = 1'b0;

    // 2: div=0, offset 0 -> one write in FILL then wr=rd every cycle
    idle_cfg(0, 0);
    en = 1'b1;
    gap_exp = 1;
    push_n(1, 1'b0);
    push_n(5, 1'b1);
    drain(20);
    chk("t2_run", state, 2);
    en = 1'b0;

    // 5: offset 511 -> 511 writes first; saturated fill keeps RUN for a later offset of 300
    idle_cfg(0, 511);
    en = 1'b1;
    push_n(511, 1'b0);
    push_n(10, 1'b1);
    drain(700);
    chk("t5_run", state, 2);
    off_val = 9'd300;
    off_req = 1'b1;
    push_n(3, 1'b1);
    cyc();
    chk("t5_ack", off_ack, 1);
    chk("t5_offset", offset, 300);
    off_req = 1'b0;
    drain(10);
    chk("t5_still_run", state, 2);
    en = 1'b0;

    // 6a: en low mid-FILL -> IDLE on the next edge, no write
    idle_cfg(0, 50);
    en = 1'b1;
    push_n(3, 1'b0);
    drain(10);
    chk("t6_fill", state, 1);
    en = 1'b0;
    cyc();
    chk("t6_idle", state, 0);
    cyc();

    // 6b: asynchronous reset mid-RUN, then restart with fill_cnt from zero
    idle_cfg(0, 2);
    en = 1'b1;
    push_n(2, 1'b0);
    push_n(2, 1'b1);
    drain(10);
    #2;
    rst = 1'b0;
    en  = 1'b0;
    #1;
    chk("arst_wr", wr, 0);
    chk("arst_rd", rd, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_off_ack", off_ack, 0);
    chk("arst_offset", offset, 0);
    chk("arst_state", state, 0);
    exp_q.delete();
    exp_ov = 1'b0;
    have_prev = 1'b0;
    cyc();
    rst = 1'b1;
    idle_cfg(0, 3);
    en = 1'b1;
    push_n(3, 1'b0);
    push_n(2, 1'b1);
    drain(20);
    chk("t6_restart_run", state, 2);
    en = 1'b0;
    cyc();
    cyc();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
